// File: rtl/ram_pkg.sv
// Shared definitions for the parameterised RAM block: default geometry,
// wait-counter width and the request FSM state encoding.
package ram_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DEPTH  = 1024;
    localparam int DEF_WAIT   = 2;

    // Wait counter must hold WAIT-1 for WAIT up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ram_array.sv
// DEPTH x DATA_W storage split into independent byte lanes, each lane a
// plain array with synchronous write and registered, enabled read. No reset,
// so every lane maps onto block RAM.
module ram_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Caller only enables accesses for in-range addresses, so the low bits
    // are a sufficient word index.
    logic [IDX_W-1:0] idx;
    assign idx = addr[IDX_W-1:0];

    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_rdata;

        // One byte lane: write when its enable is set, read held between accesses.
        always_ff @(posedge clk) begin
            if (we && be[gi]) begin
                lane_mem[idx] <= wdata[8*gi +: 8];
            end
            if (re) begin
                lane_rdata <= lane_mem[idx];
            end
        end

        assign rdata[8*gi +: 8] = lane_rdata;
    end

endmodule

// File: rtl/param_ram.sv
// Single-outstanding request/response wrapper around ram_array with a
// programmable number of wait states between accept and memory access.
module param_ram
    import ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int WAIT   = DEF_WAIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0]    DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]   WAIT_M1 = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                wr_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [BE_W-1:0]     be_reg;
    logic                rsp_valid_reg;
    logic                rsp_err_reg;
    logic                rd_ok_reg;

    logic                accept;
    logic                acc_fire;
    logic                acc_wr;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [BE_W-1:0]     acc_be;
    logic                in_range;
    logic                mem_we;
    logic                mem_re;
    logic [DATA_W-1:0]   mem_rdata;

    assign req_ready = (state_reg == IDLE);
    assign accept    = req_valid & req_ready;

    // With no wait states the access happens on the accept edge itself, so
    // in IDLE the live request drives the memory; otherwise the latched copy.
    assign acc_wr    = (state_reg == IDLE) ? req_wr    : wr_reg;
    assign acc_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
    assign acc_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;
    assign acc_be    = (state_reg == IDLE) ? req_be    : be_reg;

    // Gated by rst_n so a request presented during reset never touches memory.
    assign acc_fire = rst_n & ((WAIT == 0) ? accept
                                           : ((state_reg == BUSY) && (cnt_reg == '0)));
    assign in_range = ({1'b0, acc_addr} < DEPTH_L);
    assign mem_we   = acc_fire &  acc_wr & in_range;
    assign mem_re   = acc_fire & ~acc_wr & in_range;

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .be    (acc_be),
        .addr  (acc_addr),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    // The array's read register only loads on an access, so it holds through
    // RESP; it is masked to zero for writes, errors and outside RESP.
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rd_ok_reg ? mem_rdata : '0;

    // Request FSM: latch on accept, count wait states, present response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            wr_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            be_reg        <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rd_ok_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        wr_reg    <= req_wr;
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        be_reg    <= req_be;
                        if (WAIT == 0) begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= ~in_range;
                            rd_ok_reg     <= ~acc_wr & in_range;
                        end else begin
                            state_reg <= BUSY;
                            cnt_reg   <= WAIT_M1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_reg == '0) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= ~in_range;
                        rd_ok_reg     <= ~acc_wr & in_range;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        rsp_err_reg   <= 1'b0;
                        rd_ok_reg     <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 10, word address width.
REQ-003 Parameter DEPTH, default 1024, number of words; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004 Parameter WAIT, default 2, access wait states; legal range 0..15.
REQ-005 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  block can accept a request.
REQ-009 req_wr  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_W  word address.
REQ-011 req_wdata  in  DATA_W  write data.
REQ-012 req_be  in  DATA_W/8  byte enables for writes; bit i covers bits 8i+7..8i.
REQ-013 rsp_valid  out  1  response present.
REQ-014 rsp_ready  in  1  consumer accepts response.
REQ-015 rsp_rdata  out  DATA_W  read data; 0 for writes and errored requests.
REQ-016 rsp_err  out  1  request address >= DEPTH.

Function
REQ-017 FSM states SHALL be IDLE, BUSY, RESP; exactly one request in flight.
REQ-018 req_ready SHALL be 1 only in IDLE; accept = req_valid & req_ready at a rising edge.
REQ-019 On accept, wr/addr/wdata/be SHALL be latched; later changes to req_* inputs SHALL NOT affect the access.
REQ-020 On accept, WAIT=0: go to RESP directly, performing the access on that edge; WAIT>0: go to BUSY with wait counter = WAIT-1.
REQ-021 In BUSY, counter decrements each cycle; on the edge where counter is 0, access is performed and state goes to RESP.
REQ-022 Latency: accept at edge N -> rsp_valid high from edge N+WAIT+1 onward.
REQ-023 Write access SHALL update only bytes with be=1; be=0 write SHALL complete normally with memory unchanged.
REQ-024 Read access SHALL capture mem[addr] into rsp_rdata register.
REQ-025 addr >= DEPTH: no memory change, rsp_rdata=0, rsp_err=1; all other responses rsp_err=0.
REQ-026 rsp_valid, rsp_rdata, rsp_err SHALL be registered and held stable in RESP until rsp_valid & rsp_ready.
REQ-027 On response handshake, state goes to IDLE; req_ready rises the following cycle (no same-cycle bypass).
REQ-028 req_valid while not in IDLE SHALL be ignored (not queued).

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, counter 0, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-030 Reset mid-operation (BUSY or RESP) SHALL abandon the request; a write not yet performed SHALL NOT occur.
REQ-031 Memory array SHALL NOT be cleared by reset; contents undefined at power-up.

Structure
REQ-032 Shared package ram_pkg SHALL hold the state enum (IDLE, BUSY, RESP) and default constants for DATA_W, ADDR_W, DEPTH, WAIT.
REQ-033 Storage SHALL be sub-module ram_array: DEPTH x DATA_W, byte-enable synchronous write, synchronous read, no reset; FSM and handshake live in param_ram.

Verification
REQ-034 Defaults; write addr 5, data 0xDEADBEEF, be 0xF, then read addr 5 -> read rsp_rdata=0xDEADBEEF, rsp_err=0, each rsp_valid exactly 3 cycles after accept.
REQ-035 Memory[7]=0x11223344; write addr 7 data 0xAABBCCDD be 0x5 -> subsequent read returns 0x11BB33DD.
REQ-036 Read addr 1023 OK; with DEPTH=1000, write addr 1000 -> rsp_err=1, rsp_rdata=0, read of addr 1000 modulo-aliased words (e.g. addr 0) unchanged.
REQ-037 Hold rsp_ready=0 for 10 cycles in RESP while toggling req_* -> rsp_valid/rsp_rdata stable, req_ready=0, no extra response after release.
REQ-038 Assert rst_n=0 in BUSY of a write to addr 3 (prior 0x0) -> outputs at reset values asynchronously; later read addr 3 returns 0x0.
REQ-039 WAIT=0 build; back-to-back reads with rsp_ready=1 -> rsp_valid 1 cycle after each accept, one accept every 2 cycles.
